// File: rtl/conv_overlap_add_if.sv
// Handshake bundle for conv_overlap_add: packed result words in, convolution samples out.
// The slave modport is the block's own view; the master modport is the producer/consumer side.
interface conv_overlap_add_if #(
    parameter int OUT_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_result;
    logic             in_last;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_sample;
    logic             out_last;
    logic             busy;

    modport master (
        output in_valid, in_result, in_last, out_ready,
        input  in_ready, out_valid, out_sample, out_last, busy
    );

    modport slave (
        input  in_valid, in_result, in_last, out_ready,
        output in_ready, out_valid, out_sample, out_last, busy
    );
endinterface

// File: rtl/conv_overlap_add.sv
// Overlap-add stage: folds y4..y6 of each block into y0..y2 of the next and streams samples out.
// Build option OLA_SATURATE_EN: clamp sums to 2^OUT_W-1 instead of wrapping.
module conv_overlap_add #(
    parameter int NIB_W = 4,
    parameter int OUT_W = 5
) (
    input  logic                clk,
    input  logic                rst,
    conv_overlap_add_if.slave   bus
);
    localparam int LANES = 7;
    localparam int SUM_W = (OUT_W > NIB_W + 1) ? OUT_W : NIB_W + 1;
    localparam logic [OUT_W-1:0] SAMPLE_MAX = '1;

    typedef enum logic [1:0] {IDLE, EMIT, FLUSH} state_t;

    state_t           state_reg, state_next;
    logic [1:0]       idx_reg, idx_next;
    logic             last_reg, last_next;
    logic [OUT_W-1:0] s_reg [4];
    logic [OUT_W-1:0] s_next [4];
    logic [NIB_W-1:0] tail_reg [3];
    logic [NIB_W-1:0] tail_next [3];

    logic [NIB_W-1:0] lane [LANES];
    logic [OUT_W-1:0] sum_w [4];
    logic             in_ready_w, out_valid_w, out_last_w;
    logic [OUT_W-1:0] out_sample_w;
    logic             unused_bits;

    // Narrow a full-precision sum to the output width.
    function automatic logic [OUT_W-1:0] fit(input logic [SUM_W-1:0] v);
`ifdef OLA_SATURATE_EN
        return (v > SUM_W'(SAMPLE_MAX)) ? SAMPLE_MAX : v[OUT_W-1:0];
`else
        return v[OUT_W-1:0];
`endif
    endfunction

    genvar gi;
    generate
        for (gi = 0; gi < LANES; gi++) begin : g_lane
            assign lane[gi] = bus.in_result[gi*NIB_W +: NIB_W];
        end
        for (gi = 0; gi < 4; gi++) begin : g_sum
            if (gi < 3) begin : g_ola
                assign sum_w[gi] = fit(SUM_W'(lane[gi]) + SUM_W'(tail_reg[gi]));
            end else begin : g_pass
                assign sum_w[gi] = fit(SUM_W'(lane[gi]));
            end
        end
    endgenerate

    // The top nibble is padding in the packed result word.
    assign unused_bits = ^bus.in_result[31:LANES*NIB_W];

    always_comb begin
        state_next   = state_reg;
        idx_next     = idx_reg;
        last_next    = last_reg;
        s_next       = s_reg;
        tail_next    = tail_reg;
        in_ready_w   = 1'b0;
        out_valid_w  = 1'b0;
        out_last_w   = 1'b0;
        out_sample_w = '0;
        case (state_reg)
            IDLE: begin
                in_ready_w = 1'b1;
                if (bus.in_valid) begin
                    state_next = EMIT;
                    idx_next   = 2'd0;
                    last_next  = bus.in_last;
                    for (int i = 0; i < 4; i++) s_next[i] = sum_w[i];
                    for (int i = 0; i < 3; i++) tail_next[i] = lane[4+i];
                end
            end
            EMIT: begin
                out_valid_w  = 1'b1;
                out_sample_w = s_reg[idx_reg];
                if (bus.out_ready) begin
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == 2'd3) begin
                        idx_next   = 2'd0;
                        state_next = last_reg ? FLUSH : IDLE;
                    end
                end
            end
            FLUSH: begin
                out_valid_w = 1'b1;
                out_last_w  = (idx_reg == 2'd2);
                case (idx_reg)
                    2'd0:    out_sample_w = fit(SUM_W'(tail_reg[0]));
                    2'd1:    out_sample_w = fit(SUM_W'(tail_reg[1]));
                    default: out_sample_w = fit(SUM_W'(tail_reg[2]));
                endcase
                if (bus.out_ready) begin
                    idx_next = idx_reg + 2'd1;
                    if (idx_reg == 2'd2) begin
                        idx_next   = 2'd0;
                        state_next = IDLE;
                        last_next  = 1'b0;
                        for (int i = 0; i < 3; i++) tail_next[i] = '0;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg <= IDLE;
            idx_reg   <= 2'd0;
            last_reg  <= 1'b0;
            for (int i = 0; i < 4; i++) s_reg[i] <= '0;
            for (int i = 0; i < 3; i++) tail_reg[i] <= '0;
        end else begin
            state_reg <= state_next;
            idx_reg   <= idx_next;
            last_reg  <= last_next;
            s_reg     <= s_next;
            tail_reg  <= tail_next;
        end
    end

    assign bus.in_ready   = in_ready_w;
    assign bus.out_valid  = out_valid_w;
    assign bus.out_sample = out_sample_w;
    assign bus.out_last   = out_last_w;
    assign bus.busy       = (state_reg != IDLE);
endmodule

// File: tb/tb_conv_overlap_add.sv
// Scoreboard bench for conv_overlap_add: directed blocks push expected samples, monitors pop and compare.
// A second instance with OUT_W=4 exercises the wrap/saturate corner.
module tb_conv_overlap_add;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   compared   = 0;
    int   mismatched = 0;

    logic [5:0] q5[$];   // {last, sample[4:0]}
    logic [4:0] q4[$];   // {last, sample[3:0]}

    conv_overlap_add_if #(.OUT_W(5)) bus5 ();
    conv_overlap_add_if #(.OUT_W(4)) bus4 ();

    conv_overlap_add #(.NIB_W(4), .OUT_W(5)) dut5 (.clk(clk), .rst(rst), .bus(bus5.slave));
    conv_overlap_add #(.NIB_W(4), .OUT_W(4)) dut4 (.clk(clk), .rst(rst), .bus(bus4.slave));

    always #5 clk = ~clk;

    // Monitors: a transfer is committed at the next rising edge, so inspect at the falling edge.
    always @(negedge clk) begin
        if (!rst && bus5.out_valid && bus5.out_ready) begin
            logic [5:0] e;
            compared++;
            if (q5.size() == 0) begin
                mismatched++;
                $display("FAIL w5_unexpected got sample=%0d last=%0b", bus5.out_sample, bus5.out_last);
            end else begin
                e = q5.pop_front();
                if ({bus5.out_last, bus5.out_sample} !== e) begin
                    mismatched++;
                    $display("FAIL w5_sample got sample=%0d last=%0b want sample=%0d last=%0b",
                             bus5.out_sample, bus5.out_last, e[4:0], e[5]);
                end else
                    $display("w5 sample=%0d last=%0b ok", bus5.out_sample, bus5.out_last);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && bus4.out_valid && bus4.out_ready) begin
            logic [4:0] e;
            compared++;
            if (q4.size() == 0) begin
                mismatched++;
                $display("FAIL w4_unexpected got sample=%0d last=%0b", bus4.out_sample, bus4.out_last);
            end else begin
                e = q4.pop_front();
                if ({bus4.out_last, bus4.out_sample} !== e) begin
                    mismatched++;
                    $display("FAIL w4_sample got sample=%0h last=%0b want sample=%0h last=%0b",
                             bus4.out_sample, bus4.out_last, e[3:0], e[4]);
                end else
                    $display("w4 sample=%0h last=%0b ok", bus4.out_sample, bus4.out_last);
            end
        end
    end

    task automatic check(input string name, input int got, input int want);
        compared++;
        if (got !== want) begin
            mismatched++;
            $display("FAIL %s got=%0d want=%0d", name, got, want);
        end else
            $display("%s = %0d ok", name, got);
    endtask

    task automatic push5(input logic [4:0] smp, input logic last);
        q5.push_back({last, smp});
    endtask

    task automatic push4(input logic [3:0] smp, input logic last);
        q4.push_back({last, smp});
    endtask

    // Present one word to the selected instance; returns 1 ns after the accepting edge.
    task automatic send(input bit narrow, input logic [31:0] word, input logic last);
        bit done = 1'b0;
        @(posedge clk); #1;
        if (narrow) begin bus4.in_valid = 1'b1; bus4.in_result = word; bus4.in_last = last; end
        else        begin bus5.in_valid = 1'b1; bus5.in_result = word; bus5.in_last = last; end
        for (int c = 0; c < 50 && !done; c++) begin
            @(negedge clk);
            done = narrow ? bus4.in_ready : bus5.in_ready;
        end
        if (!done) begin
            compared++; mismatched++;
            $display("FAIL send_timeout got in_ready=0 want in_ready=1 word=%08h", word);
        end
        @(posedge clk); #1;
        bus4.in_valid = 1'b0;
        bus5.in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        bit done = 1'b0;
        for (int c = 0; c < 200 && !done; c++) begin
            @(negedge clk);
            done = (q5.size() == 0) && (q4.size() == 0) && !bus5.busy && !bus4.busy;
        end
        if (!done) begin
            compared++; mismatched++;
            $display("FAIL drain_timeout got pending=%0d want pending=0", q5.size() + q4.size());
        end
    endtask

    initial begin
        bus5.in_valid = 1'b0; bus5.in_result = '0; bus5.in_last = 1'b0; bus5.out_ready = 1'b1;
        bus4.in_valid = 1'b0; bus4.in_result = '0; bus4.in_last = 1'b0; bus4.out_ready = 1'b1;

        // Reset state, then an asynchronous mid-cycle reset.
        #3;
        check("reset_out_valid", int'(bus5.out_valid), 0);
        check("reset_busy", int'(bus5.busy), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("async_out_valid", int'(bus5.out_valid), 0);
        check("async_out_last", int'(bus5.out_last), 0);
        check("async_busy", int'(bus5.busy), 0);
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("post_reset_in_ready", int'(bus5.in_ready), 1);

        // Single last block: 1..7, last on 7.
        for (int i = 1; i <= 7; i++) push5(5'(i), i == 7);
        send(1'b0, 32'h0765_4321, 1'b1);
        wait_drain();

        // Padding nibble must not matter.
        for (int i = 1; i <= 7; i++) push5(5'(i), i == 7);
        send(1'b0, 32'hA765_4321, 1'b1);
        wait_drain();

        // Two blocks with carry: 1,2,3,4, 6,7,8,1, 1,1,1.
        push5(5'd1, 0); push5(5'd2, 0); push5(5'd3, 0); push5(5'd4, 0);
        send(1'b0, 32'h0765_4321, 1'b0);
        push5(5'd6, 0); push5(5'd7, 0); push5(5'd8, 0); push5(5'd1, 0);
        push5(5'd1, 0); push5(5'd1, 0); push5(5'd1, 1);
        send(1'b0, 32'h0111_1111, 1'b1);
        wait_drain();

        // Backpressure while sample 3 is shown.
        for (int i = 1; i <= 7; i++) push5(5'(i), i == 7);
        send(1'b0, 32'h0765_4321, 1'b1);
        @(posedge clk);
        @(posedge clk); #1 bus5.out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("hold_sample", int'(bus5.out_sample), 3);
            check("hold_in_ready", int'(bus5.in_ready), 0);
        end
        @(posedge clk); #1 bus5.out_ready = 1'b1;
        wait_drain();

        // Reset after two samples of a block whose tail is all F; next block must see zero tail.
        push5(5'd0, 0); push5(5'd0, 0);
        send(1'b0, 32'h0FFF_0000, 1'b0);
        @(posedge clk);
        @(posedge clk); #2 rst = 1'b1;
        #1;
        check("mid_emit_out_valid", int'(bus5.out_valid), 0);
        check("mid_emit_busy", int'(bus5.busy), 0);
        check("mid_emit_pending", q5.size(), 0);
        @(posedge clk); #1 rst = 1'b0;
        push5(5'd1, 0);
        for (int i = 0; i < 6; i++) push5(5'd0, i == 5);
        send(1'b0, 32'h0000_0001, 1'b1);
        wait_drain();

        // OUT_W=4: y4=F carried onto y0=F gives 0x1E, which clamps or wraps.
        for (int i = 0; i < 4; i++) push4(4'd0, 0);
        send(1'b1, 32'h000F_0000, 1'b0);
`ifdef OLA_SATURATE_EN
        push4(4'hF, 0);
`else
        push4(4'hE, 0);
`endif
        for (int i = 0; i < 6; i++) push4(4'd0, i == 5);
        send(1'b1, 32'h0000_000F, 1'b1);
        wait_drain();

        check("final_pending", q5.size() + q4.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
